// File: rtl/countn_updown.sv
// countn_updown: parametrised up/down modulo-MODULUS counter with parallel
// load, count enable, one-shot stop and terminal-count / wrap outputs.
//
// Optional feature: define COUNTN_STICKY_OVF_EN to add a sticky overflow
// flag (ports ovf_clr / ovf). Without the macro, neither port exists.
//
// State table:
//   state      | meaning
//   S_COUNTING | counter free to advance on enabled edges (done = 0)
//   S_DONE     | one-shot reached terminal value, count frozen (done = 1)
//
// Arithmetic wraps at MODULUS, not at 2**WIDTH, so for a non power-of-two
// MODULUS the values MODULUS..2**WIDTH-1 can never be reached: loads above
// the range saturate at MODULUS-1.

module countn_updown #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 64,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up,
  input  logic             oneshot,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             done
`ifdef COUNTN_STICKY_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic {
    S_COUNTING = 1'b0,
    S_DONE     = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_val;
  logic             tc_int;
  logic             step_ok;

  // Terminal value depends on direction; re-evaluates as soon as up changes.
  always_comb begin
    tc_int = 1'b0;
    if (up) begin
      tc_int = (cnt_q == MAX_VAL);
    end else begin
      tc_int = (cnt_q == '0);
    end
  end

  // Out-of-range load values clamp to the top of the count range.
  always_comb begin
    load_val = MAX_VAL;
    if ({1'b0, data} < MOD_EXT) begin
      load_val = data;
    end
  end

  assign step_ok = en && (state_q == S_COUNTING);

  // Next count, state and wrap pulse; load beats enable, done freezes count.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    if (load) begin
      cnt_d   = load_val;
      state_d = S_COUNTING;
    end else if (step_ok) begin
      if (!tc_int) begin
        if (up) begin
          cnt_d = cnt_q + ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end else if (!oneshot) begin
        if (up) begin
          cnt_d = '0;
        end else begin
          cnt_d = MAX_VAL;
        end
        wrap_d = 1'b1;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= RST_CNT;
      state_q <= S_COUNTING;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = cnt_q;
  assign tc   = tc_int;
  assign wrap = wrap_q;
  assign done = (state_q == S_DONE);

`ifdef COUNTN_STICKY_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a wrap on the same edge as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (wrap_d) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register; load leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_countn_updown.sv
// Bench for countn_updown with WIDTH=6, MODULUS=10, RST_VAL=3.
module tb_countn_updown;

  localparam int W   = 6;
  localparam int M   = 10;
  localparam int RV  = 3;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] data;
  logic         up;
  logic         oneshot;
  logic [W-1:0] cnt_out;
  logic         tc;
  logic         wrap;
  logic         done;
`ifdef COUNTN_STICKY_OVF_EN
  logic         ovf_clr;
  logic         ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_out  = 0;
  int m_done = 0;
  int m_wrap = 0;
  int m_ovf  = 0;

  countn_updown #(.WIDTH(W), .MODULUS(M), .RST_VAL(RV)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .data    (data),
    .up      (up),
    .oneshot (oneshot),
    .out     (cnt_out),
    .tc      (tc),
    .wrap    (wrap),
    .done    (done)
`ifdef COUNTN_STICKY_OVF_EN
    ,
    .ovf_clr (ovf_clr),
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int model_tc(input int v, input logic u);
    return u ? int'(v == M - 1) : int'(v == 0);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".out"},  int'(cnt_out), m_out);
    check({tag, ".wrap"}, int'(wrap),    m_wrap);
    check({tag, ".done"}, int'(done),    m_done);
    check({tag, ".tc"},   int'(tc),      model_tc(m_out, up));
`ifdef COUNTN_STICKY_OVF_EN
    check({tag, ".ovf"},  int'(ovf),     m_ovf);
`endif
  endtask

  // Apply inputs for one edge, advance the model from the counter's rules,
  // then sample 1 time unit after the edge.
  task automatic step(input string tag, input logic r, input logic l,
                      input logic e, input logic u, input logic os,
                      input int d, input logic clr);
    int t;
    rst = r; load = l; en = e; up = u; oneshot = os; data = W'(d);
`ifdef COUNTN_STICKY_OVF_EN
    ovf_clr = clr;
`else
    if (clr) ;
`endif
    t = model_tc(m_out, u);
    if (r) begin
      m_out = RV; m_done = 0; m_wrap = 0; m_ovf = 0;
    end else begin
      m_wrap = 0;
      if (l) begin
        m_out  = (d < M) ? d : M - 1;
        m_done = 0;
      end else if (e && m_done == 0) begin
        if (t == 1 && os) begin
          m_done = 1;
        end else begin
          m_out  = u ? (m_out + 1) % M : (m_out + M - 1) % M;
          m_wrap = t;
        end
      end
      if (clr) m_ovf = 0;
      if (m_wrap == 1) m_ovf = 1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; data = '0; up = 1'b1; oneshot = 1'b0;
`ifdef COUNTN_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    @(negedge clk);

    // reset and load
    step("rst0", 1, 0, 0, 1, 0, 0, 0);
    step("rst1", 1, 0, 0, 1, 0, 0, 0);
    check("rst_out_const", int'(cnt_out), 3);
    step("ld8",  0, 1, 0, 1, 0, 8, 0);
    check("ld8_const", int'(cnt_out), 8);

    // free-running wrap upward
    step("up9",  0, 0, 1, 1, 0, 0, 0);
    check("tc_at9_const", int'(tc), 1);
    step("up0",  0, 0, 1, 1, 0, 0, 0);
    check("wrap_at0_const", int'(wrap), 1);
    step("up1",  0, 0, 1, 1, 0, 0, 0);
    check("wrap_drop_const", int'(wrap), 0);

    // tc follows up without a clock edge
    up = 1'b0; #1;
    check("tc_dir_dn", int'(tc), model_tc(m_out, up));
    up = 1'b1; #1;

    // down count into one-shot stop
    step("ld2",  0, 1, 0, 0, 1, 2, 0);
    step("dn1",  0, 0, 1, 0, 1, 0, 0);
    step("dn0",  0, 0, 1, 0, 1, 0, 0);
    check("tc_at0_const", int'(tc), 1);
    step("dn_d", 0, 0, 1, 0, 1, 0, 0);
    check("done_rise_const", int'(done), 1);
    step("dn_h", 0, 0, 1, 1, 0, 0, 0);
    check("done_hold_out_const", int'(cnt_out), 0);
    step("ld5",  0, 1, 1, 0, 1, 5, 0);
    check("rearm_const", int'(done), 0);
    step("dn4",  0, 0, 1, 0, 1, 0, 0);
    step("dn3",  0, 0, 1, 0, 1, 0, 0);

    // down wrap 0 -> 9 and modulo-2 style back-to-back pulses not applicable;
    // saturation and priority
    step("ld0",  0, 1, 0, 0, 0, 0, 0);
    step("dnwr", 0, 0, 1, 0, 0, 0, 0);
    check("dn_wrap_const", int'(cnt_out), 9);
    step("sat",  0, 1, 1, 1, 0, 13, 0);
    check("sat_const", int'(cnt_out), 9);
    step("sat63", 0, 1, 0, 1, 0, 63, 0);
    step("rstld", 1, 1, 1, 1, 0, 5, 0);
    check("rst_over_ld_const", int'(cnt_out), 3);

    // mid-count reset
    step("ld6",  0, 1, 0, 1, 0, 6, 0);
    step("up7",  0, 0, 1, 1, 0, 0, 0);
    step("rstm", 1, 0, 1, 1, 0, 0, 0);
    step("res",  0, 0, 1, 1, 0, 0, 0);

    // overflow clear interplay (model tracks ovf even if the port is absent)
    step("ld9",  0, 1, 0, 1, 0, 9, 0);
    step("wrA",  0, 0, 1, 1, 0, 0, 0);
    step("clr",  0, 0, 0, 1, 0, 0, 1);
    step("ld9b", 0, 1, 0, 1, 0, 9, 0);
    step("wrclr", 0, 0, 1, 1, 0, 0, 1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step("rnd",
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 75),
           logic'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 30),
           int'($urandom_range(0, 63)),
           ($urandom_range(0, 99) < 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
